// File: rtl/rv32i_io_pkg.sv
// Shared types and sizes for the RV32I IO bus controller.
package rv32i_io_pkg;

    localparam int unsigned IO_SPACE_BIT       = 31;
    localparam int unsigned IO_ADDR_W          = IO_SPACE_BIT - 1;
    localparam int unsigned IO_BE_W            = 4;
    localparam int unsigned IO_DATA_W          = 32;
    localparam int unsigned IO_CNT_W           = 16;
    localparam int unsigned IO_TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } io_state_t;

    typedef struct packed {
        logic                 we;
        logic [IO_ADDR_W-1:0] addr;
        logic [IO_BE_W-1:0]   be;
        logic [IO_DATA_W-1:0] wdata;
    } io_bus_req_t;

endpackage

// File: rtl/rv32i_io_timeout.sv
// REQ-phase watchdog: clears on request acceptance, counts REQ cycles, flags the last allowed one.
module rv32i_io_timeout
    import rv32i_io_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = IO_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc_c
);

    logic [IO_CNT_W-1:0] cnt_q;
    logic [IO_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + IO_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_c = en && (cnt_q == IO_CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/rv32i_io_bus_ctrl.sv
// Sequences memory-stage IO accesses onto a handshaked IO bus, stalling until ack.
// Optional REQ timeout abort is enabled by defining IO_TIMEOUT_EN.
module rv32i_io_bus_ctrl
    import rv32i_io_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = IO_TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 io_rd,
    input  logic                 io_we,
    input  logic [IO_ADDR_W-1:0] io_addr,
    input  logic [IO_BE_W-1:0]   io_be,
    input  logic [IO_DATA_W-1:0] io_wdata,
    output logic                 io_stall,
    output logic [IO_DATA_W-1:0] io_rdata,
    output logic                 io_err,
    output logic                 bus_req,
    output logic                 bus_we,
    output logic [IO_ADDR_W-1:0] bus_addr,
    output logic [IO_BE_W-1:0]   bus_be,
    output logic [IO_DATA_W-1:0] bus_wdata,
    input  logic                 bus_ack,
    input  logic [IO_DATA_W-1:0] bus_rdata
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    io_state_t            state_q, state_d;
    io_bus_req_t          bus_q, bus_d;
    logic                 bus_req_q, bus_req_d;
    logic [IO_DATA_W-1:0] io_rdata_q, io_rdata_d;
    logic                 io_err_q, io_err_d;
    logic                 req_c;
    logic                 timeout_c;

    assign req_c = io_rd || io_we;

`ifdef IO_TIMEOUT_EN
    rv32i_io_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (clk),
        .reset (reset),
        .clr   ((state_q == IDLE) && req_c),
        .en    (state_q == REQ),
        .tc_c  (timeout_c)
    );
`else
    assign timeout_c = 1'b0;
`endif

    // Next-state and registered-output logic; ack only matters in REQ.
    always_comb begin
        state_d    = state_q;
        bus_d      = bus_q;
        bus_req_d  = 1'b0;
        io_rdata_d = io_rdata_q;
        io_err_d   = io_err_q;
        case (state_q)
            IDLE: begin
                if (req_c) begin
                    bus_d.we    = io_we;
                    bus_d.addr  = io_addr;
                    bus_d.be    = io_be;
                    bus_d.wdata = io_wdata;
                    io_err_d    = 1'b0;
                    bus_req_d   = 1'b1;
                    state_d     = REQ;
                end
            end
            REQ: begin
                bus_req_d = 1'b1;
                if (bus_ack) begin
                    if (!bus_q.we) begin
                        io_rdata_d = bus_rdata;
                    end
                    io_err_d  = 1'b0;
                    bus_req_d = 1'b0;
                    state_d   = DONE;
                end else if (timeout_c) begin
                    io_rdata_d = '0;
                    io_err_d   = 1'b1;
                    bus_req_d  = 1'b0;
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            bus_q      <= '0;
            bus_req_q  <= 1'b0;
            io_rdata_q <= '0;
            io_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bus_q      <= bus_d;
            bus_req_q  <= bus_req_d;
            io_rdata_q <= io_rdata_d;
            io_err_q   <= io_err_d;
        end
    end

    // Reset gates the stall so an aborted access releases the pipeline at once.
    assign io_stall  = !reset && (((state_q == IDLE) && req_c) || (state_q == REQ));
    assign io_rdata  = io_rdata_q;
    assign io_err    = io_err_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_q.we;
    assign bus_addr  = bus_q.addr;
    assign bus_be    = bus_q.be;
    assign bus_wdata = bus_q.wdata;

endmodule

// File: tb/tb_rv32i_io_bus_ctrl.sv
// Directed self-checking bench for rv32i_io_bus_ctrl (timeout cases when IO_TIMEOUT_EN is defined).
module tb_rv32i_io_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        io_rd = 1'b0;
    logic        io_we = 1'b0;
    logic [29:0] io_addr = '0;
    logic [3:0]  io_be = '0;
    logic [31:0] io_wdata = '0;
    logic        io_stall;
    logic [31:0] io_rdata;
    logic        io_err;
    logic        bus_req;
    logic        bus_we;
    logic [29:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    int checks = 0;
    int failures = 0;

    rv32i_io_bus_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .io_rd     (io_rd),
        .io_we     (io_we),
        .io_addr   (io_addr),
        .io_be     (io_be),
        .io_wdata  (io_wdata),
        .io_stall  (io_stall),
        .io_rdata  (io_rdata),
        .io_err    (io_err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"},   32'(bus_req),   32'h0);
        check({tag, "_stall"}, 32'(io_stall),  32'h0);
        check({tag, "_we"},    32'(bus_we),    32'h0);
        check({tag, "_addr"},  32'(bus_addr),  32'h0);
        check({tag, "_be"},    32'(bus_be),    32'h0);
        check({tag, "_wdata"}, bus_wdata,      32'h0);
        check({tag, "_rdata"}, io_rdata,       32'h0);
        check({tag, "_err"},   32'(io_err),    32'h0);
    endtask

    // Drives one access from the current cycle until DONE (stall low); ack_at=0 means never ack.
    task automatic run_access(input logic rd, input logic we, input logic [29:0] addr,
                              input logic [3:0] be, input logic [31:0] wd,
                              input int ack_at, input logic [31:0] rdata,
                              output int req_cyc, output int stall_cyc, output bit payload_ok);
        bit done = 1'b0;
        req_cyc = 0;
        stall_cyc = 0;
        payload_ok = 1'b1;
        io_rd = rd;
        io_we = we;
        io_addr = addr;
        io_be = be;
        io_wdata = wd;
        #1;
        for (int i = 0; i < 50 && !done; i++) begin
            if (!io_stall) begin
                done = 1'b1;
            end else begin
                stall_cyc++;
                if (bus_req) begin
                    req_cyc++;
                    if (bus_we !== we || bus_addr !== addr || bus_be !== be || bus_wdata !== wd)
                        payload_ok = 1'b0;
                    if (req_cyc == ack_at) begin
                        bus_ack = 1'b1;
                        bus_rdata = rdata;
                    end
                end
                @(posedge clk);
                #1;
                bus_ack = 1'b0;
                #1;
            end
        end
        check("access_completes", 32'(done), 32'h1);
    endtask

    int  rq, st;
    bit  pok;

    initial begin
        // Reset state
        #2;
        check_all_zero("reset");
        #10;
        reset = 1'b0;
        tick();
        check("idle_stall", 32'(io_stall), 32'h0);

        // Load with ack in the 4th REQ cycle
        run_access(1'b1, 1'b0, 30'h2000_0001, 4'hF, 32'h0, 4, 32'hA5A5_1234, rq, st, pok);
        check("load_req_cycles",   32'(rq), 32'd4);
        check("load_stall_cycles", 32'(st), 32'd5);
        check("load_payload",      32'(pok), 32'h1);
        check("load_rdata",        io_rdata, 32'hA5A5_1234);
        check("load_err",          32'(io_err), 32'h0);
        check("load_done_req",     32'(bus_req), 32'h0);
        tick();
        io_rd = 1'b0;
        #1;
        check("load_idle_stall",   32'(io_stall), 32'h0);

        // Store with immediate ack leaves io_rdata unchanged
        tick();
        run_access(1'b0, 1'b1, 30'h2000_0010, 4'b0011, 32'h0000_BEEF, 1, 32'h1111_2222, rq, st, pok);
        check("store_req_cycles",   32'(rq), 32'd1);
        check("store_stall_cycles", 32'(st), 32'd2);
        check("store_payload",      32'(pok), 32'h1);
        check("store_rdata_kept",   io_rdata, 32'hA5A5_1234);
        tick();
        io_we = 1'b0;

        // Read and write together behave as a write
        tick();
        run_access(1'b1, 1'b1, 30'h2000_0020, 4'b1000, 32'h7700_0000, 2, 32'h3333_4444, rq, st, pok);
        check("rdwe_payload",    32'(pok), 32'h1);
        check("rdwe_rdata_kept", io_rdata, 32'hA5A5_1234);
        tick();
        io_rd = 1'b0;
        io_we = 1'b0;

        // Back-to-back loads: one idle cycle between DONE and the second request
        tick();
        run_access(1'b1, 1'b0, 30'h2000_0100, 4'hF, 32'h0, 2, 32'hCAFE_0001, rq, st, pok);
        check("b2b_first_rdata", io_rdata, 32'hCAFE_0001);
        tick();
        check("b2b_gap_req", 32'(bus_req), 32'h0);
        run_access(1'b1, 1'b0, 30'h2000_0104, 4'hF, 32'h0, 1, 32'hCAFE_0002, rq, st, pok);
        check("b2b_second_req_cycles", 32'(rq), 32'd1);
        check("b2b_second_payload",    32'(pok), 32'h1);
        check("b2b_second_rdata",      io_rdata, 32'hCAFE_0002);
        tick();
        io_rd = 1'b0;
        #1;

        // Spurious ack in IDLE
        bus_ack = 1'b1;
        bus_rdata = 32'hDEAD_DEAD;
        tick();
        bus_ack = 1'b0;
        #1;
        check("spur_idle_req",   32'(bus_req), 32'h0);
        check("spur_idle_rdata", io_rdata, 32'hCAFE_0002);

        // Spurious ack in DONE after a store
        run_access(1'b0, 1'b1, 30'h2000_0200, 4'b0001, 32'h0000_00AA, 1, 32'h0, rq, st, pok);
        bus_ack = 1'b1;
        bus_rdata = 32'hFFFF_FFFF;
        tick();
        bus_ack = 1'b0;
        io_we = 1'b0;
        #1;
        check("spur_done_rdata", io_rdata, 32'hCAFE_0002);
        check("spur_done_req",   32'(bus_req), 32'h0);
        tick();
        check("spur_done_req2",  32'(bus_req), 32'h0);

`ifdef IO_TIMEOUT_EN
        // No ack: abort after 8 REQ cycles
        run_access(1'b1, 1'b0, 30'h2000_0300, 4'hF, 32'h0, 0, 32'h0, rq, st, pok);
        check("to_req_cycles", 32'(rq), 32'd8);
        check("to_err",        32'(io_err), 32'h1);
        check("to_rdata",      io_rdata, 32'h0);
        tick();
        io_rd = 1'b0;
        // Ack in the 8th REQ cycle wins
        tick();
        run_access(1'b1, 1'b0, 30'h2000_0304, 4'hF, 32'h0, 8, 32'h5A5A_0008, rq, st, pok);
        check("to_ack_req_cycles", 32'(rq), 32'd8);
        check("to_ack_err",        32'(io_err), 32'h0);
        check("to_ack_rdata",      io_rdata, 32'h5A5A_0008);
        tick();
        io_rd = 1'b0;
`else
        // Without the watchdog a long wait still completes normally
        run_access(1'b1, 1'b0, 30'h2000_0300, 4'hF, 32'h0, 12, 32'h5A5A_000C, rq, st, pok);
        check("long_req_cycles", 32'(rq), 32'd12);
        check("long_err",        32'(io_err), 32'h0);
        check("long_rdata",      io_rdata, 32'h5A5A_000C);
        tick();
        io_rd = 1'b0;
`endif

        // Reset asserted mid-REQ drops request and stall without a clock edge
        tick();
        io_we = 1'b1;
        io_addr = 30'h2000_0400;
        io_be = 4'b1111;
        io_wdata = 32'h1234_5678;
        tick();
        tick();
        check("rst_pre_req", 32'(bus_req), 32'h1);
        #1;
        reset = 1'b1;
        #1;
        check("rst_async_req",   32'(bus_req), 32'h0);
        check("rst_async_stall", 32'(io_stall), 32'h0);
        io_we = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        check_all_zero("rst_after");
        tick();
        check("rst_idle_req", 32'(bus_req), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
